// File: rtl/vliw_mem_arbiter.sv
// Data-memory port arbiter: latches a bundle's memory requests and serves them
// one at a time, lowest slot first, through a single-port memory.
module vliw_mem_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 32,
    parameter int DW   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bundle_valid,
    input  logic [NREQ-1:0]      req_mask,
    input  logic [NREQ-1:0]      req_we,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_wdata,
    output logic                 stall,
    output logic                 bundle_done,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [NREQ*DW-1:0]   rsp_rdata,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [AW-1:0]        mem_addr,
    output logic [DW-1:0]        mem_wdata,
    input  logic [DW-1:0]        mem_rdata
);

    localparam int CW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP, DONE} state_t;

    state_t              state, state_nxt;
    logic [NREQ-1:0]     pending, pending_clr, we_r;
    logic [NREQ*AW-1:0]  addr_r;
    logic [NREQ*DW-1:0]  wdata_r;
    logic [CW-1:0]       cur;
    logic                accept;

    // Fixed priority: scanning from the top down leaves the lowest set slot in cur.
    always_comb begin
        cur = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (pending[NREQ-1-i])
                cur = CW'(NREQ - 1 - i);
        end
        pending_clr = pending & ~(NREQ'(1) << cur);
    end

    always_comb begin
        accept      = !rst && (state == IDLE) && bundle_valid && (|req_mask);
        state_nxt   = state;
        stall       = 1'b0;
        bundle_done = 1'b0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        case (state)
            IDLE: begin
                stall = accept;
                if (accept)
                    state_nxt = ISSUE;
            end
            ISSUE: begin
                stall     = 1'b1;
                mem_en    = 1'b1;
                mem_we    = we_r[cur];
                mem_addr  = addr_r[cur*AW +: AW];
                mem_wdata = wdata_r[cur*DW +: DW];
                state_nxt = RESP;
            end
            RESP: begin
                stall     = 1'b1;
                state_nxt = (|pending_clr) ? ISSUE : DONE;
            end
            DONE: begin
                bundle_done = 1'b1;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pending   <= '0;
            we_r      <= '0;
            addr_r    <= '0;
            wdata_r   <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                pending   <= req_mask;
                we_r      <= req_we;
                addr_r    <= req_addr;
                wdata_r   <= req_wdata;
                rsp_valid <= '0;
                rsp_rdata <= '0;
            end
            if (state == RESP) begin
                pending        <= pending_clr;
                rsp_valid[cur] <= 1'b1;
                if (!we_r[cur])
                    rsp_rdata[cur*DW +: DW] <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_vliw_mem_arbiter.sv
// Directed self-checking bench for vliw_mem_arbiter with a synchronous memory model.
module tb_vliw_mem_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         bundle_valid;
    logic [3:0]   req_mask, req_we;
    logic [127:0] req_addr, req_wdata;
    logic         stall, bundle_done;
    logic [3:0]   rsp_valid;
    logic [127:0] rsp_rdata;
    logic         mem_en, mem_we;
    logic [31:0]  mem_addr, mem_wdata, mem_rdata;

    logic [31:0]  mem [256];
    int           checks = 0, failures = 0;

    int           n_stall, done_cyc, n_done, n_iss;
    int           iss_cyc [8];
    logic [31:0]  iss_addr [8];
    logic [31:0]  iss_wd [8];
    logic         iss_we [8];

    vliw_mem_arbiter #(.NREQ(4), .AW(32), .DW(32)) dut (
        .clk(clk), .rst(rst), .bundle_valid(bundle_valid), .req_mask(req_mask),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .bundle_done(bundle_done), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Read data is only meaningful the cycle after a read; otherwise a marker value.
    always @(posedge clk) begin
        mem_rdata <= 32'h0BAD_0BAD;
        if (mem_en) begin
            if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[7:0]];
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents a bundle for one cycle, scrambles the request inputs afterwards,
    // and records stall/done/memory activity over a fixed 24-cycle window.
    task automatic run_bundle(input logic [3:0] m, input logic [3:0] w,
                              input logic [127:0] a, input logic [127:0] d);
        n_stall = 0; done_cyc = 0; n_done = 0; n_iss = 0;
        for (int c = 1; c <= 24; c++) begin
            if (c == 1) begin
                bundle_valid = 1'b1; req_mask = m; req_we = w; req_addr = a; req_wdata = d;
            end else if (c == 2) begin
                bundle_valid = 1'b0; req_mask = 4'hF; req_we = ~w;
                req_addr = {4{32'h0000_00EE}}; req_wdata = '1;
            end
            #1;
            if (stall) n_stall++;
            if (bundle_done) begin
                n_done++;
                if (done_cyc == 0) done_cyc = c;
            end
            if (mem_en && n_iss < 8) begin
                iss_cyc[n_iss] = c; iss_addr[n_iss] = mem_addr;
                iss_wd[n_iss] = mem_wdata; iss_we[n_iss] = mem_we;
                n_iss++;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h10] = 32'hDEAD_BEEF;
        mem[8'h21] = 32'h1111_0001;
        mem[8'h23] = 32'h3333_0003;
        mem[8'h30] = 32'h0000_3030;
        mem[8'h31] = 32'h0000_3131;
        mem[8'h40] = 32'h0000_0099;
        rst = 1'b1; bundle_valid = 1'b0; req_mask = '0; req_we = '0;
        req_addr = '0; req_wdata = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_stall", stall, 0);
        chk("reset_mem_en", mem_en, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single load, slot 2, address 0x10
        run_bundle(4'b0100, 4'b0000, {32'h0, 32'h10, 32'h0, 32'h0}, '0);
        chk("single_stall_cycles", n_stall, 3);
        chk("single_done_cycle", done_cyc, 4);
        chk("single_done_pulses", n_done, 1);
        chk("single_issues", n_iss, 1);
        chk("single_issue_cycle", iss_cyc[0], 2);
        chk("single_addr", iss_addr[0], 32'h10);
        chk("single_we", iss_we[0], 0);
        chk("single_rsp_valid", rsp_valid, 4'b0100);
        chk("single_rdata", rsp_rdata, {32'h0, 32'hDEAD_BEEF, 64'h0});

        // All four slots, stores in slots 0 and 2
        run_bundle(4'b1111, 4'b0101, {32'h23, 32'h22, 32'h21, 32'h20},
                   {32'hB3, 32'hA2, 32'hB1, 32'hA0});
        chk("all4_stall_cycles", n_stall, 9);
        chk("all4_done_cycle", done_cyc, 10);
        chk("all4_issues", n_iss, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("all4_cyc%0d", i), iss_cyc[i], 2 + 2 * i);
            chk($sformatf("all4_addr%0d", i), iss_addr[i], 32'h20 + i);
            chk($sformatf("all4_we%0d", i), iss_we[i], (i % 2 == 0) ? 1 : 0);
        end
        chk("all4_wdata0", iss_wd[0], 32'hA0);
        chk("all4_wdata2", iss_wd[2], 32'hA2);
        chk("all4_mem_write", mem[8'h22], 32'hA2);
        chk("all4_rsp_valid", rsp_valid, 4'b1111);
        chk("all4_rdata", rsp_rdata, {32'h3333_0003, 32'h0, 32'h1111_0001, 32'h0});

        // Store then load of the same address within one bundle
        run_bundle(4'b1010, 4'b0010, {32'h40, 32'h0, 32'h40, 32'h0}, {96'h0, 32'h55, 32'h0} >> 0);
        chk("order_stall_cycles", n_stall, 5);
        chk("order_done_cycle", done_cyc, 6);
        chk("order_rdata", rsp_rdata, {32'h55, 32'h0, 32'h0, 32'h0});
        chk("order_rsp_valid", rsp_valid, 4'b1010);

        // Empty mask with bundle_valid: nothing happens
        run_bundle(4'b0000, 4'b0000, {4{32'h10}}, '0);
        chk("empty_stall", n_stall, 0);
        chk("empty_issues", n_iss, 0);
        chk("empty_done", n_done, 0);

        // Latched addresses survive input changes mid-bundle
        run_bundle(4'b0011, 4'b0000, {32'h0, 32'h0, 32'h31, 32'h30}, '0);
        chk("held_issues", n_iss, 2);
        chk("held_addr0", iss_addr[0], 32'h30);
        chk("held_addr1", iss_addr[1], 32'h31);
        chk("held_rdata", rsp_rdata, {64'h0, 32'h3131, 32'h3030});

        // Back-to-back: bundle held valid across DONE
        bundle_valid = 1'b1; req_mask = 4'b0001; req_we = '0;
        req_addr = {96'h0, 32'h10}; req_wdata = '0;
        #1; chk("b2b_c1_stall", stall, 1);
        @(negedge clk); #1; chk("b2b_c2_mem_en", mem_en, 1);
        @(negedge clk); #1; chk("b2b_c3_mem_en", mem_en, 0);
        @(negedge clk); #1;
        chk("b2b_c4_done", bundle_done, 1);
        chk("b2b_c4_stall", stall, 0);
        chk("b2b_c4_mem_en", mem_en, 0);
        @(negedge clk); #1;
        chk("b2b_c5_stall", stall, 1);
        chk("b2b_c5_done", bundle_done, 0);
        chk("b2b_c5_rsp_valid", rsp_valid, 4'b0001);
        @(negedge clk); #1;
        chk("b2b_c6_rsp_valid", rsp_valid, 4'b0000);
        chk("b2b_c6_mem_en", mem_en, 1);
        bundle_valid = 1'b0;
        @(negedge clk); @(negedge clk); #1;
        chk("b2b_c8_done", bundle_done, 1);
        chk("b2b_c8_rdata", rsp_rdata, {96'h0, 32'hDEAD_BEEF});
        @(negedge clk);

        // Reset during the second ISSUE of a two-request bundle
        bundle_valid = 1'b1; req_mask = 4'b0011; req_we = '0;
        req_addr = {64'h0, 32'h23, 32'h21}; req_wdata = '0;
        @(negedge clk); bundle_valid = 1'b0;
        @(negedge clk); @(negedge clk); #1;
        chk("rst_pre_mem_en", mem_en, 1);
        chk("rst_pre_addr", mem_addr, 32'h23);
        chk("rst_pre_rsp_valid", rsp_valid, 4'b0001);
        rst = 1'b1; #1;
        chk("rst_stall", stall, 0);
        chk("rst_done", bundle_done, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        @(negedge clk); rst = 1'b0;
        n_done = 0; n_iss = 0; n_stall = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (bundle_done) n_done++;
            if (mem_en) n_iss++;
            if (stall) n_stall++;
            @(negedge clk);
        end
        chk("rst_after_done", n_done, 0);
        chk("rst_after_mem_en", n_iss, 0);
        chk("rst_after_stall", n_stall, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/vliw_mem_arbiter.md
# vliw_mem_arbiter

Data-memory port arbiter for the VLIW processor. Each bundle can carry memory operations in several slots, but the data memory has a single port. This block latches all of a bundle's memory requests, serves them one at a time in ascending slot order, and stalls the processor until every request has completed. It sits between the processor's load/store slots and the single-port data memory.

## Interface
Parameters:
- NREQ, 4: number of memory-capable slots (requesters).
- AW, 32: address width.
- DW, 32: data width.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- bundle_valid  in  1  current bundle presented; sampled only in IDLE.
- req_mask  in  NREQ  bit i set means slot i has a memory op this bundle.
- req_we  in  NREQ  bit i: 1 = store, 0 = load.
- req_addr  in  NREQ*AW  slot i address at [i*AW +: AW].
- req_wdata  in  NREQ*DW  slot i store data at [i*DW +: DW].
- stall  out  1  processor must hold its bundle/PC.
- bundle_done  out  1  one-cycle pulse; all requests of the bundle are complete.
- rsp_valid  out  NREQ  bit i set once slot i is served; held until next bundle accepted.
- rsp_rdata  out  NREQ*DW  load data per slot; 0 for store slots.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  write enable, qualified by mem_en.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  read data, valid the cycle after mem_en with mem_we=0.

## Operation
- States: IDLE, ISSUE, RESP, DONE.
- **IDLE**
  - If bundle_valid and req_mask != 0: latch mask into pending[], and latch we/addr/wdata. Clear rsp_valid and rsp_rdata. Go to ISSUE.
  - If bundle_valid and req_mask == 0: no action, no stall, no bundle_done.
- **ISSUE**
  - Select cur = lowest set index in pending (fixed priority, slot 0 highest). This gives deterministic in-bundle ordering.
  - Drive mem_en=1, mem_we=we[cur], mem_addr=addr[cur], mem_wdata=wdata[cur] for exactly this cycle.
  - Go to RESP.
- **RESP**
  - Set rsp_valid[cur] and clear pending[cur].
  - If a load: rsp_rdata slot cur <= mem_rdata. If a store: rsp_rdata slot cur stays 0.
  - If pending (after clearing) != 0, go to ISSUE; else go to DONE.
- **DONE**
  - bundle_done=1, then go to IDLE.
- stall = (IDLE & bundle_valid & |req_mask) | ISSUE | RESP. stall is combinational from state and inputs, and is 0 in DONE.
- mem_en, mem_we, mem_addr and mem_wdata are 0 outside ISSUE.
- Inputs are ignored outside IDLE; later changes to req_* do not affect a latched bundle.
- Same-address store and load in one bundle resolve in slot order. The lower slot takes effect first.

## Timing
- Reset (async, immediate): state=IDLE, pending=0, rsp_valid=0, rsp_rdata=0, stall=0, bundle_done=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Reset mid-bundle aborts the bundle. Remaining requests are dropped, and no bundle_done pulse is produced.
- Latency for a bundle with N = popcount(req_mask) requests:
  - acceptance edge, then 2 cycles per request (ISSUE + RESP), then 1 DONE cycle.
  - stall is high for 2N+1 cycles: the acceptance cycle plus 2N.
  - bundle_done is high in cycle 2N+2, counting the acceptance cycle as 1.
- Memory ops are never back-to-back: at least one idle memory cycle separates them.
- A new bundle is accepted at earliest in the cycle after DONE, i.e. from IDLE.

## Test plan
- **Reset state:** assert rst mid-ISSUE -> all outputs 0 immediately; state IDLE; no bundle_done pulse follows.
- **Single load:** slot 2 load, addr 0x10, memory returns 0xDEADBEEF.
  - mem_en/mem_addr=0x10 for 1 cycle; rsp_rdata slot 2 = 0xDEADBEEF.
  - stall high 3 cycles; bundle_done on cycle 4.
- **All four slots** (mask=4'b1111, mixed we=4'b0101):
  - memory sees slots 0,1,2,3 in order, each 2 cycles apart; stall high 9 cycles.
  - rsp_rdata is 0 for store slots 0 and 2.
- **Ordering:** slot 1 stores 0x55 at A and slot 3 loads A in the same bundle -> slot 3 rsp_rdata = 0x55.
- **Empty and held inputs:**
  - bundle_valid with mask=0 -> stall stays 0; no mem_en; no bundle_done.
  - changing req_addr mid-bundle does not alter the issued addresses.
- **Back-to-back bundles:** second bundle presented continuously is accepted only in the IDLE cycle after DONE. rsp_valid is cleared at that acceptance.
